// File: rtl/fetch_decode_queue.sv
// ============================================================================
// Module   : fetch_decode_queue
// Purpose  : Instruction FIFO between fetch and the stage-1 format decoder.
//            Each accepted instruction gets a unique 64-bit major ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    input  logic                               fetchValid_i,
    output logic                               fetchReady_o,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    output logic                               outputEnable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic [queueIndexWidth:0]           occupancy_o
);

    localparam logic [queueIndexWidth:0]           c_full_count = queueDepth[queueIndexWidth:0];
    localparam logic [queueIndexWidth:0]           c_count_one  = 1;
    localparam logic [queueIndexWidth-1:0]         c_ptr_one    = 1;
    localparam logic [instructionCounterWidth-1:0] c_maj_one    = 1;

    logic [instructionWidth-1:0]        r_mem_instr [queueDepth];
    logic [addressWidth-1:0]            r_mem_addr  [queueDepth];
    logic [PidSize-1:0]                 r_mem_pid   [queueDepth];
    logic [TidSize-1:0]                 r_mem_tid   [queueDepth];
    logic [instructionCounterWidth-1:0] r_mem_maj   [queueDepth];

    logic [queueIndexWidth-1:0]         r_wr_ptr;
    logic [queueIndexWidth-1:0]         r_rd_ptr;
    logic [queueIndexWidth:0]           r_count;
    logic [instructionCounterWidth-1:0] r_maj_counter;

    logic                               r_out_en;
    logic [instructionWidth-1:0]        r_out_instr;
    logic [addressWidth-1:0]            r_out_addr;
    logic [PidSize-1:0]                 r_out_pid;
    logic [TidSize-1:0]                 r_out_tid;
    logic [instructionCounterWidth-1:0] r_out_maj;

    logic w_full;
    logic w_push;
    logic w_pop;

    // Acceptance depends only on the pre-edge count: a full queue never
    // accepts, even while popping, which keeps ready free of input paths.
    assign w_full = (r_count == c_full_count);
    assign w_push = fetchValid_i && !w_full && !flush_i;
    assign w_pop  = !stall_i && !flush_i && (r_count != '0);

    always_ff @(posedge clock_i) begin
        if (w_push && !reset_i) begin
            r_mem_instr[r_wr_ptr] <= instruction_i;
            r_mem_addr[r_wr_ptr]  <= instructionAddress_i;
            r_mem_pid[r_wr_ptr]   <= instructionPid_i;
            r_mem_tid[r_wr_ptr]   <= instructionTid_i;
            r_mem_maj[r_wr_ptr]   <= r_maj_counter;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_maj_counter <= '0;
        end else begin
            // The ID counter survives flushes so IDs stay unique.
            if (w_push) begin
                r_maj_counter <= r_maj_counter + c_maj_one;
            end
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_count_one;
                    2'b01:   r_count <= r_count - c_count_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_out_en    <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
            r_out_pid   <= '0;
            r_out_tid   <= '0;
            r_out_maj   <= '0;
        end else if (flush_i) begin
            r_out_en <= 1'b0;
        end else if (!stall_i) begin
            r_out_en <= w_pop;
            if (w_pop) begin
                r_out_instr <= r_mem_instr[r_rd_ptr];
                r_out_addr  <= r_mem_addr[r_rd_ptr];
                r_out_pid   <= r_mem_pid[r_rd_ptr];
                r_out_tid   <= r_mem_tid[r_rd_ptr];
                r_out_maj   <= r_mem_maj[r_rd_ptr];
            end
        end
    end

    assign fetchReady_o         = !w_full;
    assign occupancy_o          = r_count;
    assign outputEnable_o       = r_out_en;
    assign instruction_o        = r_out_instr;
    assign instructionAddress_o = r_out_addr;
    assign instructionPid_o     = r_out_pid;
    assign instructionTid_o     = r_out_tid;
    assign instructionMajId_o   = r_out_maj;

endmodule

`default_nettype wire

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch unit and the decode stage-1 format decoder.
- Buffers fetched instructions together with their address, PID and TID.
- Stamps each accepted instruction with a unique 64-bit major ID.
- Presents one instruction per cycle to the format decoder's enable/data inputs, honouring downstream stall and pipeline flush.

Parameters:
addressWidth, 64, instruction address width
instructionWidth, 32, instruction word width (4-byte fixed)
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID width
queueDepth, 8, entry count; must be a power of 2, at least 2
queueIndexWidth, 3, log2(queueDepth)

Ports:
clock_i  in  1  clock, all state updates on the rising edge
reset_i  in  1  synchronous, active-high reset
flush_i  in  1  discard all queued and output instructions
stall_i  in  1  downstream stall; hold the output registers
fetchValid_i  in  1  fetch presents an instruction this cycle
fetchReady_o  out  1  queue can accept; equals !full, derived from registered state only
instruction_i  in  instructionWidth  fetched instruction word
instructionAddress_i  in  addressWidth  fetched instruction address
instructionPid_i  in  PidSize  process ID
instructionTid_i  in  TidSize  thread ID
outputEnable_o  out  1  output registers hold a valid instruction; drives the format decoder enable
instruction_o  out  instructionWidth  registered instruction
instructionAddress_o  out  addressWidth  registered address
instructionPid_o  out  PidSize  registered PID
instructionTid_o  out  TidSize  registered TID
instructionMajId_o  out  instructionCounterWidth  registered major ID
occupancy_o  out  queueIndexWidth+1  current entry count, 0..queueDepth

Behaviour:
- Reset (reset_i=1 at edge):
  - Read/write pointers, count, major ID counter, every output register and outputEnable_o go to 0.
  - fetchReady_o=1 after reset.
  - Reset overrides flush, stall and push.
- Push: when fetchValid_i && fetchReady_o && !flush_i:
  - Write {instruction, address, pid, tid, majCounter} at the write pointer.
  - Write pointer increments mod queueDepth.
  - majCounter increments, wrapping 2^64-1 -> 0.
- fetchValid_i while full: ignored. No write, no counter increment. Fetch must hold its data.
- Pop: when !stall_i && !flush_i:
  - If count>0: head entry loads into the output registers, outputEnable_o<=1, read pointer increments mod queueDepth.
  - If count==0: outputEnable_o<=0; data outputs hold their last values.
- Stall (stall_i=1, no flush): output registers and outputEnable_o hold unchanged. No pop. Push still permitted.
- Push and pop in the same cycle: count unchanged.
  - fetchReady_o is computed from the pre-edge count, so a full queue refuses a push even in a pop cycle. There is no pass-through.
- No bypass: an instruction pushed at edge k is visible on the outputs at the earliest after edge k+1 (1-cycle queue latency, empty queue, no stall).
- Flush (flush_i=1, no reset):
  - Pointers and count go to 0; outputEnable_o<=0.
  - The same-cycle push is dropped.
  - majCounter is NOT reset, so IDs stay unique across flushes.
  - Flush has priority over stall.
- occupancy_o and fetchReady_o reflect the registered count. No combinational path from any input to any output.
- Ordering: strict FIFO. Major IDs on outputEnable_o cycles are strictly increasing (mod 2^64) between flushes.

Test Plan:
- Reset, then push 3 instructions (0x48000010, 0x7C0802A6, 0x38210010) on consecutive cycles with stall_i=0. Required: outputEnable_o rises 1 cycle after the first push; outputs show the three words in order with major IDs 0, 1, 2; occupancy_o never exceeds 1.
- Hold stall_i=1 and push 8 instructions. Required: occupancy_o reaches 8 and fetchReady_o=0. A 9th fetchValid_i is ignored and majCounter stays 8. Release stall: the 8 entries drain one per cycle with IDs 0..7, then outputEnable_o=0.
- Full queue, stall_i=0, fetchValid_i held high. Required: the push is refused in the cycle the pop frees an entry; it is accepted the next cycle; occupancy_o reads 8 -> 7 -> 7.
- Hold stall_i=1 for 3 cycles with a valid output. Required: instruction_o, instructionMajId_o and outputEnable_o are unchanged for all 3 cycles.
- With 5 entries queued and outputEnable_o=1, assert flush_i for 1 cycle, with a push and stall_i=1 in the same cycle. Required: next cycle occupancy_o=0 and outputEnable_o=0; the dropped push does not advance the ID. The next accepted push gets ID 5 if 5 were accepted before.
- Preload majCounter near wrap by pushing up to 2^64-2 (force/backdoor), then push 3. Required: IDs 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF, 0x0.
- Assert reset_i mid-drain with stall and flush both high. Required: all outputs 0, occupancy_o=0, fetchReady_o=1; next push gets ID 0.
